rx_iq_arbiter: RTL

RX_IQ_ARBITER -- requirements
Module: rx_iq_arbiter

---
 rtl/rx_iq_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/rx_iq_arbiter.sv
// rx_iq_arbiter: voice and spectrum IQ samples each queue in their own FIFO and
// share one registered output port. Voice has priority; a saturating wait
// counter forces a spectrum grant after SPEC_MAX_WAIT voice grants in a row.

// Single-clock FIFO with wrap-around pointers and a one-bit-wider count, so
// full and empty are distinguished by the count difference.
module rx_iq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   empty_o,
    output logic                   drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
    logic             full;
    logic             push_ok;

    assign level_o = wr_cnt_q - rd_cnt_q;
    assign empty_o = (level_o == '0);
    assign full    = (level_o == CW'(DEPTH));
    assign rdata_o = mem_q[rd_cnt_q[AW-1:0]];

    // Push acceptance, drop detection and next pointer values.
    // NOTE: every signal assigned here is given a value on every path; a missed branch would infer a latch.
    always_comb begin
        // A full FIFO still takes the push when its head leaves at the same edge.
        push_ok  = push_i && (!full || pop_i);
        drop_o   = push_i && full && !pop_i;
        wr_cnt_d = push_ok ? wr_cnt_q + CW'(1) : wr_cnt_q;
        rd_cnt_d = pop_i   ? rd_cnt_q + CW'(1) : rd_cnt_q;
    end

    // Pointer registers; reset empties the FIFO.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Sample storage written at the tail.
    // NOTE: storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem_q[wr_cnt_q[AW-1:0]] <= wdata_i;
        end
    end
endmodule

module rx_iq_arbiter #(
    parameter int DEPTH         = 4,
    parameter int SPEC_MAX_WAIT = 3
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic signed [15:0]     VOICE_I,
    input  logic signed [15:0]     VOICE_Q,
    input  logic                   voice_valid,
    input  logic signed [15:0]     SPEC_I,
    input  logic signed [15:0]     SPEC_Q,
    input  logic                   spec_valid,
    input  logic                   out_ready,
    input  logic                   ovf_clear,
    output logic signed [15:0]     out_I,
    output logic signed [15:0]     out_Q,
    output logic                   out_src,
    output logic                   out_valid,
    output logic [$clog2(DEPTH):0] voice_level,
    output logic [$clog2(DEPTH):0] spec_level,
    output logic                   voice_overflow,
    output logic                   spec_overflow
);
    localparam int WW = (SPEC_MAX_WAIT < 1) ? 1 : $clog2(SPEC_MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(SPEC_MAX_WAIT);

    logic [31:0]   v_rdata, s_rdata;
    logic          v_empty, s_empty;
    logic          v_drop, s_drop;
    logic          load, grant_v, grant_s;

    logic [31:0]   out_data_q, out_data_d;
    logic          out_src_q, out_src_d;
    logic          out_valid_q, out_valid_d;
    logic [WW-1:0] spec_wait_q, spec_wait_d;
    logic          v_ovf_q, v_ovf_d;
    logic          s_ovf_q, s_ovf_d;

    rx_iq_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_voice_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push_i  (voice_valid),
        .pop_i   (grant_v),
        .wdata_i ({VOICE_I, VOICE_Q}),
        .rdata_o (v_rdata),
        .level_o (voice_level),
        .empty_o (v_empty),
        .drop_o  (v_drop)
    );

    rx_iq_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_spec_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push_i  (spec_valid),
        .pop_i   (grant_s),
        .wdata_i ({SPEC_I, SPEC_Q}),
        .rdata_o (s_rdata),
        .level_o (spec_level),
        .empty_o (s_empty),
        .drop_o  (s_drop)
    );

    // Grant decision: voice first unless spectrum has waited its maximum.
    always_comb begin
        load    = !out_valid_q || out_ready;
        grant_s = load && !s_empty && (v_empty || (spec_wait_q == WAIT_MAX));
        grant_v = load && !v_empty && !grant_s;
    end

    // Next output register, starvation counter and sticky overflow flags.
    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        spec_wait_d = spec_wait_q;

        if (grant_v) begin
            out_data_d  = v_rdata;
            out_src_d   = 1'b0;
            out_valid_d = 1'b1;
        end else if (grant_s) begin
            out_data_d  = s_rdata;
            out_src_d   = 1'b1;
            out_valid_d = 1'b1;
        end else if (load) begin
            // Nothing queued: the held word was consumed (or never valid).
            out_valid_d = 1'b0;
        end

        if (s_empty || grant_s) begin
            spec_wait_d = '0;
        end else if (grant_v && (spec_wait_q != WAIT_MAX)) begin
            spec_wait_d = spec_wait_q + WW'(1);
        end

        // Clear wins over a drop in the same cycle.
        v_ovf_d = ovf_clear ? 1'b0 : (v_ovf_q | v_drop);
        s_ovf_d = ovf_clear ? 1'b0 : (s_ovf_q | s_drop);
    end

    // Output, wait counter and flag registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            out_valid_q <= 1'b0;
            spec_wait_q <= '0;
            v_ovf_q     <= 1'b0;
            s_ovf_q     <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            spec_wait_q <= spec_wait_d;
            v_ovf_q     <= v_ovf_d;
            s_ovf_q     <= s_ovf_d;
        end
    end

    assign out_I          = out_data_q[31:16];
    assign out_Q          = out_data_q[15:0];
    assign out_src        = out_src_q;
    assign out_valid      = out_valid_q;
    assign voice_overflow = v_ovf_q;
    assign spec_overflow  = s_ovf_q;
endmodule
